// File: rtl/mem_pkg.sv
// Shared types and constants for the line-oriented memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE,
    GAP
  } state_t;

  localparam int ADDR_W         = 28;
  localparam int WORDS_PER_LINE = 4;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between a line requester (master) and mem_responder (slave).
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int MEM_WIDTH = 128
) ();

  logic                 mem_read;
  logic                 mem_write;
  logic [ADDR_W-1:0]    mem_addr;
  logic [MEM_WIDTH-1:0] mem_wdata;
  logic [MEM_WIDTH-1:0] mem_rdata;
  logic                 mem_ready;
  logic                 mem_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_err
  );

endinterface

// File: rtl/mem_lat_cnt.sv
// Loadable latency down-counter with a registered zero flag.
module mem_lat_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [7:0] cnt_q;
  logic       zero_q;

  // The flag rises one cycle after the count reaches zero; that extra cycle
  // makes the request-to-ready latency LATENCY+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= load_val_i;
      zero_q <= 1'b0;
    end else if (dec_i) begin
      if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
      zero_q <= (cnt_q == 8'd0);
    end else begin
      zero_q <= 1'b0;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency line memory: accepts one read or write, completes after
// LATENCY+1 cycles with a one-cycle ready pulse, then rests for one cycle.
module mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_NUM   = 256,
  parameter int MEM_WIDTH = 128,
  parameter int LATENCY   = 8
) (
  input logic             clk,
  input logic             mem_reset_n,
  mem_responder_if.slave  bus
);

  localparam int         IDX_W    = $clog2(MEM_NUM);
  localparam logic [7:0] LOAD_VAL = 8'(LATENCY - 1);

  logic [31:0] mem [MEM_NUM*WORDS_PER_LINE];

  state_t               state_q;
  logic                 rd_q, wr_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [MEM_WIDTH-1:0] wdata_q;
  logic [MEM_WIDTH-1:0] rdata_q;
  logic                 ready_q;
  logic                 err_q;

  logic                 req;
  logic                 cnt_load;
  logic                 cnt_dec;
  logic                 cnt_zero;
  logic                 changed;
  logic [MEM_WIDTH-1:0] line_data;

  assign req      = bus.mem_read | bus.mem_write;
  assign cnt_load = (state_q == IDLE) && req;
  assign cnt_dec  = (state_q == BUSY);

  mem_lat_cnt u_lat_cnt (
    .clk        (clk),
    .rst_n      (mem_reset_n),
    .load_i     (cnt_load),
    .load_val_i (LOAD_VAL),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  // Any change of the held request while busy is a protocol violation.
  assign changed = (bus.mem_read  != rd_q)   ||
                   (bus.mem_write != wr_q)   ||
                   (bus.mem_addr  != addr_q) ||
                   (wr_q && (bus.mem_wdata != wdata_q));

  always_comb begin
    line_data = '0;
    for (int w = 0; w < WORDS_PER_LINE; w++) begin
      line_data[32*w +: 32] = mem[{addr_q[IDX_W-1:0], 2'(w)}];
    end
  end

  always_ff @(posedge clk or negedge mem_reset_n) begin
    if (!mem_reset_n) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            rd_q    <= bus.mem_read;
            wr_q    <= bus.mem_write;
            addr_q  <= bus.mem_addr;
            wdata_q <= bus.mem_wdata;
            if (bus.mem_read && bus.mem_write) err_q <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (changed) err_q <= 1'b1;
          if (cnt_zero) begin
            state_q <= DONE;
            ready_q <= 1'b1;
            if (!wr_q) rdata_q <= line_data;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          state_q <= GAP;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // No reset here: memory contents survive reset, and an async reset has
  // already forced the FSM out of DONE so an aborted write never commits.
  always_ff @(posedge clk) begin
    if (state_q == DONE && wr_q) begin
      for (int w = 0; w < WORDS_PER_LINE; w++) begin
        mem[{addr_q[IDX_W-1:0], 2'(w)}] <= wdata_q[32*w +: 32];
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a line-level memory model.
module tb_mem_responder;

  localparam int LAT = 8;
  localparam int NUM = 256;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_responder_if #(.MEM_WIDTH(128)) bus ();

  mem_responder #(
    .MEM_NUM   (NUM),
    .MEM_WIDTH (128),
    .LATENCY   (LAT)
  ) dut (
    .clk         (clk),
    .mem_reset_n (rst_n),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0]  modelMem [NUM*4];
  logic [127:0] lastRead;
  logic         errModel;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] modelLine(input logic [27:0] a);
    int l;
    l = int'(a) % NUM;
    return {modelMem[l*4+3], modelMem[l*4+2], modelMem[l*4+1], modelMem[l*4]};
  endfunction

  task automatic modelWrite(input logic [27:0] a, input logic [127:0] d);
    int l;
    l = int'(a) % NUM;
    for (int w = 0; w < 4; w++) modelMem[l*4+w] = d[32*w +: 32];
  endtask

  // One complete transaction; called with the DUT idle, just after a rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [27:0] addr,
                               input logic [127:0] wdata, input bit glitch, input string tag);
    int n;
    bit seen;
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    @(posedge clk);
    n    = 0;
    seen = 1'b0;
    while (!seen && n <= LAT + 20) begin
      #1;
      if (bus.mem_ready) seen = 1'b1;
      else begin
        if (glitch && n == 3) bus.mem_addr = addr ^ 28'h0000001;
        @(posedge clk);
        n++;
      end
    end
    if (wr) modelWrite(addr, wdata);
    else lastRead = modelLine(addr);
    if ((rd && wr) || glitch) errModel = 1'b1;
    checkOutput({tag, "_seen"}, 128'(seen), 128'(1));
    checkOutput({tag, "_lat"}, 128'(n), 128'(LAT + 1));
    checkOutput({tag, "_rdata"}, bus.mem_rdata, lastRead);
    checkOutput({tag, "_err"}, 128'(bus.mem_err), 128'(errModel));
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(posedge clk);
    #1;
    checkOutput({tag, "_pulse"}, 128'(bus.mem_ready), 128'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Holds a read for holdCycles edges after acceptance and logs ready pulses.
  task automatic heldRead(input logic [27:0] addr, input int holdCycles,
                          output int firstPulse, output int secondPulse, output int pulses);
    bus.mem_read  = 1'b1;
    bus.mem_write = 1'b0;
    bus.mem_addr  = addr;
    firstPulse  = -1;
    secondPulse = -1;
    pulses      = 0;
    @(posedge clk);
    for (int c = 0; c < 30; c++) begin
      #1;
      if (bus.mem_ready) begin
        pulses++;
        if (firstPulse < 0) firstPulse = c;
        else if (secondPulse < 0) secondPulse = c;
      end
      if (c == holdCycles) bus.mem_read = 1'b0;
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [127:0] d;
    int p1, p2, np;
    int op;
    int quiet;

    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    rst_n         = 1'b1;
    lastRead      = '0;
    errModel      = 1'b0;
    for (int i = 0; i < NUM * 4; i++) begin
      modelMem[i] = 32'(i);
      dut.mem[i]  = 32'(i);
    end

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", 128'(bus.mem_ready), 128'(0));
    checkOutput("rst_rdata", bus.mem_rdata, 128'(0));
    checkOutput("rst_err", 128'(bus.mem_err), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b0, 28'd5, '0, 1'b0, "rd5");
    checkOutput("rd5_const", bus.mem_rdata, {32'd23, 32'd22, 32'd21, 32'd20});

    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b0, 1'b1, 28'd3, d, 1'b0, "wr3");
    applyStimulus(1'b1, 1'b0, 28'd3, '0, 1'b0, "rd3");
    checkOutput("rd3_const", bus.mem_rdata, d);
    applyStimulus(1'b1, 1'b0, 28'd4, '0, 1'b0, "rd4");
    checkOutput("rd4_const", bus.mem_rdata, {32'd19, 32'd18, 32'd17, 32'd16});

    applyStimulus(1'b1, 1'b0, 28'd257, '0, 1'b0, "rdwrap");
    checkOutput("rdwrap_const", bus.mem_rdata, {32'd7, 32'd6, 32'd5, 32'd4});

    heldRead(28'd9, LAT + 2, p1, p2, np);
    lastRead = modelLine(28'd9);
    checkOutput("hold1_first", 128'(p1), 128'(LAT + 1));
    checkOutput("hold1_pulses", 128'(np), 128'(1));
    checkOutput("hold1_rdata", bus.mem_rdata, lastRead);

    heldRead(28'd10, 2 * LAT + 6, p1, p2, np);
    lastRead = modelLine(28'd10);
    checkOutput("hold2_first", 128'(p1), 128'(LAT + 1));
    checkOutput("hold2_pulses", 128'(np), 128'(2));
    checkOutput("hold2_gap", 128'(p2 - p1 >= LAT + 3), 128'(1));
    checkOutput("hold2_rdata", bus.mem_rdata, lastRead);

    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    applyStimulus(1'b1, 1'b1, 28'd7, d, 1'b0, "both7");
    applyStimulus(1'b1, 1'b0, 28'd7, '0, 1'b0, "rd7");
    checkOutput("rd7_const", bus.mem_rdata, d);

    // Reset four cycles into a write to line 2 must abort it.
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.mem_write = 1'b1;
    bus.mem_addr  = 28'd2;
    bus.mem_wdata = d;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    lastRead = '0;
    errModel = 1'b0;
    checkOutput("abort_ready", 128'(bus.mem_ready), 128'(0));
    checkOutput("abort_rdata", bus.mem_rdata, 128'(0));
    checkOutput("abort_err", 128'(bus.mem_err), 128'(0));
    bus.mem_write = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (bus.mem_ready) quiet++;
    end
    checkOutput("abort_noready", 128'(quiet), 128'(0));
    applyStimulus(1'b1, 1'b0, 28'd2, '0, 1'b0, "rd2");
    checkOutput("rd2_const", bus.mem_rdata, {32'd11, 32'd10, 32'd9, 32'd8});

    for (int t = 0; t < 40; t++) begin
      op = int'($urandom_range(0, 9));
      d  = {$urandom(), $urandom(), $urandom(), $urandom()};
      case (op)
        0, 1, 2, 3: applyStimulus(1'b1, 1'b0, 28'($urandom()), '0, 1'b0, "rnd_rd");
        4, 5, 6, 7: applyStimulus(1'b0, 1'b1, 28'($urandom()), d, 1'b0, "rnd_wr");
        8:          applyStimulus(1'b1, 1'b1, 28'($urandom()), d, 1'b0, "rnd_both");
        default:    applyStimulus(1'b1, 1'b0, 28'($urandom()), '0, 1'b1, "rnd_glitch");
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_NUM, default 256, number of 128-bit lines held.
REQ-002 Parameter MEM_WIDTH, default 128, line width in bits; fixed at 4 x 32-bit words.
REQ-003 Parameter LATENCY, default 8, cycles from request acceptance to mem_ready; legal range 1..255.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port mem_reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port mem_read, input, 1, line read request, level, held by requester until mem_ready.
REQ-007 Port mem_write, input, 1, line write request, level, held by requester until mem_ready.
REQ-008 Port mem_addr, input, 28, line address; only low log2(MEM_NUM) bits used.
REQ-009 Port mem_wdata, input, MEM_WIDTH, write line data.
REQ-010 Port mem_rdata, output, MEM_WIDTH, read line data, registered.
REQ-011 Port mem_ready, output, 1, one-cycle completion pulse, registered.
REQ-012 Port mem_err, output, 1, sticky protocol-error flag.

Function
REQ-013 Storage SHALL be an array named mem of MEM_NUM*4 32-bit words, index = line*4 + word, word 0 in mem_rdata[31:0], so benches preload it hierarchically.
REQ-014 FSM states SHALL be IDLE, BUSY, DONE, GAP.
REQ-015 IDLE: when mem_read or mem_write is sampled high, latch addr, wdata, op; load counter with LATENCY-1; go BUSY.
REQ-016 BUSY: decrement counter each cycle; requests ignored; at counter 0 go DONE.
REQ-017 DONE: mem_ready=1 for exactly one cycle; for a read, mem_rdata SHALL hold the 4 words of the latched line in that same cycle; for a write, the 4 words SHALL be written at the end of that cycle.
REQ-018 GAP: one cycle with requests ignored, then IDLE; the next request is accepted no earlier than 2 cycles after mem_ready.
REQ-019 Total latency SHALL be LATENCY+1 cycles: request first sampled at edge N, mem_ready high after edge N+LATENCY+1.
REQ-020 mem_rdata SHALL hold its last read value outside DONE and SHALL be unchanged by writes.
REQ-021 mem_read and mem_write both high at acceptance: treated as a write; mem_err set.
REQ-022 Request deasserted or changed during BUSY: transaction completes on the latched values and mem_err is set.
REQ-023 Address bits above log2(MEM_NUM): ignored, so addresses wrap modulo MEM_NUM.
REQ-024 Read-after-write to the same line SHALL return the newly written data.

Reset
REQ-025 On mem_reset_n low, immediately: state IDLE, counter 0, mem_ready 0, mem_rdata 0, mem_err 0, latched request cleared.
REQ-026 Reset SHALL NOT clear the mem array.
REQ-027 Reset asserted mid-BUSY or mid-DONE SHALL abort the transaction with no write committed and no mem_ready pulse.
REQ-028 After reset release, the first request is sampled on the first rising edge with mem_reset_n high.

Structure
REQ-029 Shared package mem_pkg SHALL hold the FSM state enum, the address width constant (28) and the word-per-line constant (4).
REQ-030 One sub-module, mem_lat_cnt, SHALL implement the loadable down-counter with a zero flag; everything else stays in mem_responder.

Verification
REQ-031 Preload mem[i]=i; read addr 5 -> mem_ready exactly 9 cycles after the request is first sampled, mem_rdata = {23,22,21,20}.
REQ-032 Write addr 3 with {D,C,B,A} then read addr 3 -> mem_rdata = {D,C,B,A}; line 4 still {19,18,17,16}.
REQ-033 Requester holds mem_read high through mem_ready and the following cycle -> only one mem_ready pulse; second acceptance no earlier than 2 cycles after mem_ready.
REQ-034 mem_read and mem_write both high, addr 7 -> write performed, mem_err=1 and stays 1 until reset.
REQ-035 mem_reset_n pulsed low 4 cycles into a write to addr 2 -> no mem_ready, mem[8..11] unchanged, outputs 0.
REQ-036 Read addr 256+1 with MEM_NUM=256 -> returns line 1 = {7,6,5,4}.
